// File: rtl/parking_pkg.sv
`timescale 1ns/1ps
// parking_pkg
// Definitions shared by the parking lot barrier manager and its arbiter:
// the FSM state encoding, the bit positions inside the one-hot grant
// vector, and the default lot geometry and barrier timing.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    localparam int GNT_EXIT = 0;
    localparam int GNT_ENT0 = 1;
    localparam int GNT_ENT1 = 2;

    localparam int DEF_CAPACITY     = 8;
    localparam int DEF_COUNT_W      = 4;
    localparam int DEF_OPEN_CYCLES  = 16;
    localparam int DEF_CLOSE_CYCLES = 4;

endpackage

// File: rtl/parking_lot_manager_lane_arbiter.sv
`timescale 1ns/1ps
// lane_arbiter
// Combinational winner selection for the shared barrier.
// The exit lane has absolute priority. The two entrances are arbitrated
// round-robin, and rr_ptr selects the favoured entrance. Each lane is
// first masked by its eligibility flag.
// Ports:
//   exit_req  - exit lane request
//   exit_ok   - exit is eligible (the lot is not empty)
//   entry_req - entrance lane requests [1:0]
//   entry_ok  - entrances are eligible (the lot is not full)
//   rr_ptr    - favoured entrance when both entrances request
//   winner    - one-hot winner {ent1, ent0, exit}, or zero when no lane is eligible
module lane_arbiter
    import parking_pkg::*;
(
    input  logic       exit_req,
    input  logic       exit_ok,
    input  logic [1:0] entry_req,
    input  logic       entry_ok,
    input  logic       rr_ptr,
    output logic [2:0] winner
);

    logic [1:0] ent_elig;

    always_comb begin
        winner   = '0;
        ent_elig = entry_req & {2{entry_ok}};
        if (exit_req && exit_ok) begin
            winner[GNT_EXIT] = 1'b1;
        end else if (ent_elig == 2'b11) begin
            if (rr_ptr) winner[GNT_ENT1] = 1'b1;
            else        winner[GNT_ENT0] = 1'b1;
        end else if (ent_elig[0]) begin
            winner[GNT_ENT0] = 1'b1;
        end else if (ent_elig[1]) begin
            winner[GNT_ENT1] = 1'b1;
        end
    end

endmodule

// File: rtl/parking_lot_manager.sv
`timescale 1ns/1ps
// parking_lot_manager
// Drives one barrier that is shared by two entrance lanes and one exit lane.
// The sequence is: arbitrate, open the barrier for the winner, wait for
// car_passed or a timeout, adjust the free-space count, then hold a
// closing guard interval before the next grant. All outputs are registered.
// Ports:
//   clk, reset_n  - clock and asynchronous active-low reset
//   entry_req[1:0]- level requests from the entrances (held until granted)
//   exit_req      - level request from the exit (held until granted)
//   car_passed    - one-cycle pulse from the barrier loop sensor
//   grant[2:0]    - one-hot grant {ent1, ent0, exit}
//   barrier_open  - barrier actuator drive
//   free_count    - number of free spaces
//   lot_full      - high when free_count == 0
//   timeout       - one-cycle pulse when the open window expires without a pass
module parking_lot_manager
    import parking_pkg::*;
#(
    parameter int CAPACITY     = DEF_CAPACITY,
    parameter int COUNT_W      = DEF_COUNT_W,
    parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
    parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         entry_req,
    input  logic               exit_req,
    input  logic               car_passed,
    output logic [2:0]         grant,
    output logic               barrier_open,
    output logic [COUNT_W-1:0] free_count,
    output logic               lot_full,
    output logic               timeout
);

    // One counter serves as the open-window timer and as the close guard.
    localparam int TMR_MAX = (OPEN_CYCLES > CLOSE_CYCLES) ? OPEN_CYCLES : CLOSE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

    localparam logic [COUNT_W-1:0] CAP_C      = COUNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0]   OPEN_LAST  = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0]   CLOSE_LAST = TMR_W'(CLOSE_CYCLES - 1);

    state_t             state, state_d;
    logic [TMR_W-1:0]   timer, timer_d;
    logic               rr_ptr, rr_d;
    logic [2:0]         grant_d, winner;
    logic               barrier_d, timeout_d, lot_full_d;
    logic [COUNT_W-1:0] free_d;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v >= CAP_C) ? CAP_C : v + 1'b1;
    endfunction

    function automatic logic [COUNT_W-1:0] sat_dec(input logic [COUNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    lane_arbiter u_arb (
        .exit_req  (exit_req),
        .exit_ok   (free_count < CAP_C),
        .entry_req (entry_req),
        .entry_ok  (free_count != '0),
        .rr_ptr    (rr_ptr),
        .winner    (winner)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= '0;
            rr_ptr       <= 1'b0;
            grant        <= '0;
            barrier_open <= 1'b0;
            timeout      <= 1'b0;
            free_count   <= CAP_C;
            lot_full     <= 1'b0;
        end else begin
            state        <= state_d;
            timer        <= timer_d;
            rr_ptr       <= rr_d;
            grant        <= grant_d;
            barrier_open <= barrier_d;
            timeout      <= timeout_d;
            free_count   <= free_d;
            lot_full     <= lot_full_d;
        end
    end

    always_comb begin
        state_d   = state;
        timer_d   = timer;
        rr_d      = rr_ptr;
        grant_d   = grant;
        barrier_d = barrier_open;
        timeout_d = 1'b0;
        free_d    = free_count;

        case (state)
            IDLE: begin
                timer_d = '0;
                if (winner != '0) begin
                    state_d   = OPEN;
                    grant_d   = winner;
                    barrier_d = 1'b1;
                    // Move the round-robin pointer past the entrance that was served.
                    if (winner[GNT_ENT0])      rr_d = 1'b1;
                    else if (winner[GNT_ENT1]) rr_d = 1'b0;
                end
            end
            OPEN: begin
                // A pass on the last timer cycle takes precedence over the timeout.
                if (car_passed || timer == OPEN_LAST) begin
                    state_d   = CLOSE;
                    timer_d   = '0;
                    grant_d   = '0;
                    barrier_d = 1'b0;
                    if (car_passed) begin
                        if (grant[GNT_EXIT]) free_d = sat_inc(free_count);
                        else                 free_d = sat_dec(free_count);
                    end else begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            CLOSE: begin
                grant_d   = '0;
                barrier_d = 1'b0;
                if (timer == CLOSE_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                timer_d   = '0;
                grant_d   = '0;
                barrier_d = 1'b0;
            end
        endcase

        lot_full_d = (free_d == '0);
    end

endmodule

// File: tb/tb_parking_lot_manager.sv
`timescale 1ns/1ps
// tb_parking_lot_manager
// Directed bench for parking_lot_manager with the default parameters
// (CAPACITY 8, OPEN_CYCLES 16, CLOSE_CYCLES 4). Inputs are driven and
// outputs are sampled on the falling edge. The design registers on the
// rising edge.
module tb_parking_lot_manager;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] entry_req;
    logic       exit_req;
    logic       car_passed;
    logic [2:0] grant;
    logic       barrier_open;
    logic [3:0] free_count;
    logic       lot_full;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    parking_lot_manager dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .entry_req    (entry_req),
        .exit_req     (exit_req),
        .car_passed   (car_passed),
        .grant        (grant),
        .barrier_open (barrier_open),
        .free_count   (free_count),
        .lot_full     (lot_full),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    // Wait for a grant. Check how many edges it took, which lane won, and that the barrier is up.
    task automatic wait_grant(input int exp_wait, input logic [2:0] exp_gnt, input string tag);
        int n = 0;
        while (grant == 3'b000 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, exp_wait);
        check({tag, "_grant"}, grant, exp_gnt);
        check({tag, "_barrier"}, barrier_open, 1);
    endtask

    // Keep the barrier open for 'hold' observed cycles, then pulse car_passed and check the close.
    task automatic do_pass(input int hold, input int exp_free, input string tag);
        repeat (hold - 1) tick();
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        check({tag, "_grant_off"}, grant, 0);
        check({tag, "_barrier_off"}, barrier_open, 0);
        check({tag, "_free"}, free_count, exp_free);
        check({tag, "_full"}, lot_full, (exp_free == 0) ? 1 : 0);
        check({tag, "_no_timeout"}, timeout, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        int hi, pulses, g;
        reset_n    = 1'b0;
        entry_req  = 2'b00;
        exit_req   = 1'b0;
        car_passed = 1'b0;
        repeat (2) tick();
        check("rst_grant", grant, 0);
        check("rst_barrier", barrier_open, 0);
        check("rst_timeout", timeout, 0);
        check("rst_free", free_count, 8);
        check("rst_full", lot_full, 0);
        reset_n = 1'b1;

        // Empty lot: exit is never granted, and car_passed in IDLE is ignored.
        exit_req   = 1'b1;
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        g = 0;
        repeat (3) begin
            tick();
            if (grant != 3'b000) g++;
        end
        check("empty_exit_grants", g, 0);
        check("idle_pass_free", free_count, 8);
        exit_req = 1'b0;

        // Single entrance-0 pass. Then a request made during CLOSE is served 5 edges after the fall.
        entry_req = 2'b01;
        wait_grant(1, 3'b010, "e0");
        entry_req = 2'b00;
        do_pass(4, 7, "e0");
        entry_req = 2'b10;
        wait_grant(5, 3'b100, "e1_guard");
        entry_req = 2'b00;
        do_pass(2, 6, "e1");

        // Both entrances held: round-robin gives 010, 100, 010.
        do_reset();
        entry_req = 2'b11;
        wait_grant(1, 3'b010, "rr0");
        do_pass(3, 7, "rr0");
        wait_grant(5, 3'b100, "rr1");
        do_pass(3, 6, "rr1");
        wait_grant(5, 3'b010, "rr2");
        do_pass(3, 5, "rr2");

        // Exit and entrance 0 requesting together: exit wins.
        entry_req = 2'b01;
        exit_req  = 1'b1;
        wait_grant(5, 3'b001, "exprio");
        exit_req = 1'b0;
        do_pass(2, 6, "exprio");
        wait_grant(5, 3'b010, "after_exit");
        entry_req = 2'b00;
        do_pass(2, 5, "after_exit");

        // Timeout: the barrier stays up for exactly 16 cycles and timeout pulses once.
        entry_req = 2'b01;
        wait_grant(5, 3'b010, "to");
        entry_req = 2'b00;
        hi = 1;
        pulses = 0;
        while (barrier_open && hi < 40) begin
            tick();
            if (timeout) pulses++;
            if (barrier_open) hi++;
        end
        check("to_open_cycles", hi, 16);
        check("to_pulse_at_fall", timeout, 1);
        check("to_grant_off", grant, 0);
        check("to_free", free_count, 5);
        tick();
        check("to_pulse_ends", timeout, 0);
        check("to_pulse_count", pulses, 1);

        // car_passed on the final open cycle counts as a pass, with no timeout.
        entry_req = 2'b01;
        wait_grant(4, 3'b010, "lastcyc");
        entry_req = 2'b00;
        do_pass(16, 4, "lastcyc");

        // Fill the lot, with both entrances held.
        entry_req = 2'b11;
        wait_grant(5, 3'b100, "fill0");
        do_pass(2, 3, "fill0");
        wait_grant(5, 3'b010, "fill1");
        do_pass(2, 2, "fill1");
        wait_grant(5, 3'b100, "fill2");
        do_pass(2, 1, "fill2");
        wait_grant(5, 3'b010, "fill3");
        do_pass(2, 0, "fill3");
        g = 0;
        repeat (10) begin
            tick();
            if (grant != 3'b000) g++;
        end
        check("full_no_grant", g, 0);
        check("full_flag", lot_full, 1);
        exit_req = 1'b1;
        wait_grant(1, 3'b001, "full_exit");
        exit_req = 1'b0;
        do_pass(2, 1, "full_exit");
        wait_grant(5, 3'b100, "refill");
        do_pass(2, 0, "refill");
        entry_req = 2'b00;

        // Assert reset while the barrier is open with free_count 3.
        do_reset();
        entry_req = 2'b11;
        for (int i = 0; i < 5; i++) begin
            wait_grant((i == 0) ? 1 : 5, (i % 2) ? 3'b100 : 3'b010, "pre_rst");
            do_pass(2, 7 - i, "pre_rst");
        end
        wait_grant(5, 3'b100, "mid_rst_open");
        check("mid_rst_free_before", free_count, 3);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_grant", grant, 0);
        check("mid_rst_barrier", barrier_open, 0);
        check("mid_rst_free", free_count, 8);
        check("mid_rst_full", lot_full, 0);
        tick();
        reset_n = 1'b1;
        wait_grant(1, 3'b010, "post_rst_idle");
        entry_req = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
